audio_tick_scheduler: RTL and testbench
=======================================

// Module: audio_tick_scheduler
// PURPOSE
//  Sample-rate scheduler between the APB control unit and the audio datapath.
//  Buffers stereo sample pairs in a FIFO and generates the sample tick from a programmable divider.
//  On each tick it presents one pair to the DSP/output stage and requests refill at a watermark.
//  Flags underrun when a tick finds the FIFO empty.
// PARAMETERS
//  FIFO_DEPTH  16  stereo pairs held; power of 2, >=4
//  WATERMARK   8   req_out asserted while level <= WATERMARK
//  DIV_W       16  width of rate divider
// PORTS
//  clk           in   1                    clock; all logic on rising edge
//  rst           in   1                    reset, asynchronous, active-high
//  cfg_in        in   1                    strobe: load rate_div_in into divider register
//  rate_div_in   in   DIV_W                tick period in clk cycles
//  play_in       in   1                    level: 1 = run scheduler, 0 = stop
//  clr_in        in   1                    strobe: flush FIFO, clear flags and outputs
//  wr_valid_in   in   1                    sample pair valid
//  wr_audio0_in  in   24                   left sample
//  wr_audio1_in  in   24                   right sample
//  wr_ready_out  out  1                    FIFO can accept; write happens when valid&ready
//  tick_out      out  1                    one-cycle sample tick
//  audio0_out    out  24                   current left sample (registered)
//  audio1_out    out  24                   current right sample (registered)
//  play_out      out  1                    1 while in PLAY state
//  req_out       out  1                    refill request (level)
//  underrun_out  out  1                    sticky underrun flag
//  level_out     out  $clog2(FIFO_DEPTH+1) FIFO fill count
// BEHAVIOUR
//  Reset: FIFO empty, level_out=0, state IDLE, divider=2, counter=0; all outputs 0.
//  States: IDLE, PLAY. IDLE->PLAY when play_in=1; PLAY->IDLE when play_in=0, same edge.
//  Divider: cfg_in loads rate_div_in only in IDLE; ignored in PLAY. Values <2 stored as 2.
//  Counter: loaded with div-1 on IDLE->PLAY; in PLAY decrements each cycle.
//  At 0: tick_out=1 for that cycle, reload div-1. Period = div cycles.
//  First tick occurs div cycles after the edge that enters PLAY. Counter frozen in IDLE.
//  Tick with FIFO non-empty: head pair popped; audio0/1_out take it at the edge that raises tick_out.
//  Tick with FIFO empty: audio0/1_out <= 0, underrun_out <= 1 (held until clr_in or rst).
//  wr_ready_out = !full && !clr_in (combinational from registered count). Write accepted in IDLE or PLAY.
//  Simultaneous write and tick pop: both happen; level unchanged. When full, no write even if pop.
//  req_out = play_out && (level_out <= WATERMARK), evaluated from registered state.
//  clr_in: next edge level=0, pointers reset, underrun=0, audio outputs=0.
//   State and divider kept; a coincident write is dropped; a coincident tick still pulses, no pop.
//  PLAY->IDLE: tick stops; audio outputs hold last value; FIFO contents kept.
//  Pointers wrap modulo FIFO_DEPTH; level_out saturates logically at FIFO_DEPTH (never exceeds).
//  rst mid-operation: immediate return to reset values regardless of clk.
// TESTING
//  Reset: assert rst mid-PLAY with level=5 -> all outputs 0, wr_ready_out=1, state IDLE at once.
//  Rate: cfg div=4, write 3 pairs, play=1 -> ticks at cycles 4,8,12 after entry;
//   audio outputs follow FIFO order; level 3->0.
//  Underrun: div=3, 1 pair, play -> second tick drives audio=0, underrun_out=1 until clr_in.
//  Full/backpressure: write 16 pairs in IDLE -> wr_ready_out=0, 17th dropped; level_out=16.
//   Play with tick+valid at full -> level 15, no write.
//  Watermark: play with 10 pairs, div=2 -> req_out rises when level reaches 8; stays 0 in IDLE.
//  Config guard: cfg div=1 in IDLE -> period 2; cfg div=10 in PLAY -> ignored, period stays 2.

Source files
------------

// File: rtl/audio_tick_scheduler.sv
// Sample-rate scheduler: stereo-pair FIFO, programmable tick divider,
// registered audio outputs, refill request and sticky underrun flag.
module audio_tick_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int WATERMARK  = 8,
  parameter int DIV_W      = 16,
  parameter int DATA_W     = 24,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_in,
  input  logic [DIV_W-1:0]  rate_div_in,
  input  logic              play_in,
  input  logic              clr_in,
  input  logic              wr_valid_in,
  input  logic [DATA_W-1:0] wr_audio0_in,
  input  logic [DATA_W-1:0] wr_audio1_in,
  output logic              wr_ready_out,
  output logic              tick_out,
  output logic [DATA_W-1:0] audio0_out,
  output logic [DATA_W-1:0] audio1_out,
  output logic              play_out,
  output logic              req_out,
  output logic              underrun_out,
  output logic [LW-1:0]     level_out
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [DIV_W-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]            count_q;
  logic                     tick_q;
  logic                     underrun_q;
  logic signed [DATA_W-1:0] audio0_q, audio1_q;
  logic signed [DATA_W-1:0] mem0 [FIFO_DEPTH];
  logic signed [DATA_W-1:0] mem1 [FIFO_DEPTH];

  logic enter, stay, tick_evt, full, empty, wr_en, pop;

  // A divider below 2 would make the counter reload to itself forever.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

  assign enter    = (state_q == IDLE) && play_in;
  assign stay     = (state_q == PLAY) && play_in;
  assign tick_evt = stay && (cnt_q == '0);
  assign full     = (count_q == LW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready_out = !full && !clr_in;
  assign wr_en    = wr_valid_in && wr_ready_out;
  assign pop      = tick_evt && !empty && !clr_in;

  assign tick_out     = tick_q;
  assign audio0_out   = audio0_q;
  assign audio1_out   = audio1_q;
  assign play_out     = (state_q == PLAY);
  assign req_out      = play_out && (count_q <= LW'(WATERMARK));
  assign underrun_out = underrun_q;
  assign level_out    = count_q;

  // Next state, divider and tick counter; configuration only takes effect in IDLE.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && cfg_in) div_d = clamp_div(rate_div_in);
    case (state_q)
      IDLE: if (play_in) state_d = PLAY;
      PLAY: if (!play_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter) cnt_d = div_d - DIV_W'(1);
    else if (stay) cnt_d = tick_evt ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
  end

  // State, divider and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(2);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO pointers and fill count; a flush wins over any coincident write or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sample storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem0[wr_ptr_q] <= wr_audio0_in;
      mem1[wr_ptr_q] <= wr_audio1_in;
    end
  end

  // Tick pulse, audio outputs and sticky underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= 1'b0;
      audio0_q   <= '0;
      audio1_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      tick_q <= tick_evt;
      if (clr_in) begin
        audio0_q   <= '0;
        audio1_q   <= '0;
        underrun_q <= 1'b0;
      end else if (tick_evt) begin
        if (!empty) begin
          audio0_q <= mem0[rd_ptr_q];
          audio1_q <= mem1[rd_ptr_q];
        end else begin
          audio0_q   <= '0;
          audio1_q   <= '0;
          underrun_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_tick_scheduler.sv
// Testbench for audio_tick_scheduler: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_audio_tick_scheduler;

  localparam int DEPTH = 16;
  localparam int WM    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg = 1'b0;
  logic [15:0] rate = '0;
  logic        play = 1'b0;
  logic        clr = 1'b0;
  logic        wv = 1'b0;
  logic [23:0] wa0 = '0;
  logic [23:0] wa1 = '0;
  logic        ready_o, tick_o, play_o, req_o, und_o;
  logic [23:0] a0_o, a1_o;
  logic [4:0]  level_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_play;
  int          m_div;
  int          m_n;
  bit          m_tick;
  bit          m_und;
  logic [23:0] m_a0, m_a1;
  logic [47:0] m_q[$];

  audio_tick_scheduler dut (
    .clk(clk), .rst(rst), .cfg_in(cfg), .rate_div_in(rate), .play_in(play),
    .clr_in(clr), .wr_valid_in(wv), .wr_audio0_in(wa0), .wr_audio1_in(wa1),
    .wr_ready_out(ready_o), .tick_out(tick_o), .audio0_out(a0_o),
    .audio1_out(a1_o), .play_out(play_o), .req_out(req_o),
    .underrun_out(und_o), .level_out(level_o)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_play = 0; m_div = 2; m_n = 0; m_tick = 0; m_und = 0;
    m_a0 = '0; m_a1 = '0;
    m_q.delete();
  endfunction

  // Model: tick on every m_div-th PLAY edge counted from the entry edge.
  function automatic void m_update();
    int sz;
    bit rdy, wr, te;
    logic [47:0] hd;
    sz  = m_q.size();
    rdy = (sz < DEPTH) && !clr;
    wr  = wv && rdy;
    te  = m_play && play && (((m_n + 1) % m_div) == 0);
    if (clr) begin
      m_q.delete(); m_a0 = '0; m_a1 = '0; m_und = 0;
    end else begin
      if (te) begin
        if (sz > 0) begin
          hd = m_q.pop_front();
          m_a0 = hd[47:24]; m_a1 = hd[23:0];
        end else begin
          m_a0 = '0; m_a1 = '0; m_und = 1;
        end
      end
      if (wr) m_q.push_back({wa0, wa1});
    end
    m_tick = te;
    if (!m_play && cfg) m_div = (rate < 16'd2) ? 2 : int'(rate);
    if (!m_play && play) begin m_play = 1; m_n = 0; end
    else if (m_play && !play) m_play = 0;
    else if (m_play) m_n++;
  endfunction

  task automatic step();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic do_reset();
    cfg = 0; play = 0; clr = 0; wv = 0; rate = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_div(input int v);
    cfg = 1; rate = 16'(v);
    step();
    cfg = 0;
  endtask

  task automatic write_pairs(input int n, output logic [47:0] data[$]);
    data.delete();
    for (int i = 0; i < n; i++) begin
      wv = 1; wa0 = 24'($urandom); wa1 = 24'($urandom);
      data.push_back({wa0, wa1});
      step();
    end
    wv = 0;
  endtask

  task automatic test_reset();
    logic [47:0] d[$];
    n_tests++;
    if ({tick_o, a0_o, a1_o, play_o, req_o, und_o, level_o} !== '0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init got tick=%0b lvl=%0d play=%0b ready=%0b exp all 0 ready=1", tick_o, level_o, play_o, ready_o);
    end
    do_reset();
    cfg_div(100);
    write_pairs(5, d);
    play = 1;
    step(); step(); step();
    n_tests++;
    if (level_o !== 5'd5 || play_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre got lvl=%0d play=%0b exp lvl=5 play=1", level_o, play_o);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({tick_o, a0_o, a1_o, play_o, req_o, und_o, level_o} !== '0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async got lvl=%0d play=%0b req=%0b ready=%0b exp all 0 ready=1", level_o, play_o, req_o, ready_o);
    end
    play = 0;
    do_reset();
  endtask

  task automatic test_rate();
    logic [47:0] d[$];
    do_reset();
    cfg_div(4);
    write_pairs(3, d);
    play = 1;
    step();
    for (int c = 1; c <= 13; c++) begin
      step();
      n_tests++;
      if (tick_o !== ((c % 4) == 0)) begin
        n_fail++;
        $display("FAIL rate_tick c=%0d got %0b exp %0b", c, tick_o, (c % 4) == 0);
      end
      if ((c % 4) == 0) begin
        n_tests++;
        if ({a0_o, a1_o} !== d[c/4 - 1] || level_o !== 5'(3 - c/4)) begin
          n_fail++;
          $display("FAIL rate_data c=%0d got %h lvl=%0d exp %h lvl=%0d", c, {a0_o, a1_o}, level_o, d[c/4 - 1], 3 - c/4);
        end
      end
    end
    play = 0;
    step();
  endtask

  task automatic test_underrun();
    logic [47:0] d[$];
    do_reset();
    cfg_div(3);
    write_pairs(1, d);
    play = 1;
    step();
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 3) begin
        n_tests++;
        if (tick_o !== 1'b1 || {a0_o, a1_o} !== d[0] || und_o !== 1'b0) begin
          n_fail++;
          $display("FAIL under_first got tick=%0b data=%h und=%0b exp 1 %h 0", tick_o, {a0_o, a1_o}, und_o, d[0]);
        end
      end
    end
    n_tests++;
    if (tick_o !== 1'b1 || {a0_o, a1_o} !== 48'h0 || und_o !== 1'b1) begin
      n_fail++;
      $display("FAIL under_second got tick=%0b data=%h und=%0b exp 1 0 1", tick_o, {a0_o, a1_o}, und_o);
    end
    play = 0;
    step(); step();
    n_tests++;
    if (und_o !== 1'b1) begin
      n_fail++;
      $display("FAIL under_sticky got %0b exp 1", und_o);
    end
    clr = 1;
    step();
    clr = 0;
    n_tests++;
    if (und_o !== 1'b0) begin
      n_fail++;
      $display("FAIL under_clr got %0b exp 0", und_o);
    end
  endtask

  task automatic test_full();
    logic [47:0] d[$];
    do_reset();
    write_pairs(16, d);
    n_tests++;
    if (ready_o !== 1'b0 || level_o !== 5'd16) begin
      n_fail++;
      $display("FAIL full_ready got ready=%0b lvl=%0d exp 0 16", ready_o, level_o);
    end
    wv = 1; wa0 = 24'h123456; wa1 = 24'h654321;
    step();
    n_tests++;
    if (level_o !== 5'd16) begin
      n_fail++;
      $display("FAIL full_drop got lvl=%0d exp 16", level_o);
    end
    cfg_div(2);
    play = 1;
    step();
    step();
    step();
    n_tests++;
    if (tick_o !== 1'b1 || level_o !== 5'd15 || {a0_o, a1_o} !== d[0]) begin
      n_fail++;
      $display("FAIL full_pop got tick=%0b lvl=%0d data=%h exp 1 15 %h", tick_o, level_o, {a0_o, a1_o}, d[0]);
    end
    wv = 0; play = 0;
    step();
  endtask

  task automatic test_watermark();
    logic [47:0] d[$];
    do_reset();
    write_pairs(10, d);
    n_tests++;
    if (req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wm_idle got %0b exp 0", req_o);
    end
    cfg_div(2);
    play = 1;
    step();
    for (int c = 1; c <= 6; c++) begin
      step();
      n_tests++;
      if (req_o !== (c >= 4) || level_o !== 5'(10 - c/2)) begin
        n_fail++;
        $display("FAIL wm_play c=%0d got req=%0b lvl=%0d exp %0b %0d", c, req_o, level_o, c >= 4, 10 - c/2);
      end
    end
    play = 0;
    step();
    n_tests++;
    if (req_o !== 1'b0 || play_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wm_stop got req=%0b play=%0b exp 0 0", req_o, play_o);
    end
  endtask

  task automatic test_cfg_guard();
    do_reset();
    cfg_div(1);
    play = 1;
    step();
    for (int c = 1; c <= 14; c++) begin
      if (c == 7) begin cfg = 1; rate = 16'd10; end
      step();
      cfg = 0;
      n_tests++;
      if (tick_o !== ((c % 2) == 0)) begin
        n_fail++;
        $display("FAIL cfg_tick c=%0d got %0b exp %0b", c, tick_o, (c % 2) == 0);
      end
    end
    play = 0;
    step();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) play = ~play;
      cfg  = ($urandom_range(0, 9) == 0);
      rate = 16'($urandom_range(0, 6));
      clr  = ($urandom_range(0, 59) == 0);
      wv   = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70));
      wa0  = 24'($urandom);
      wa1  = 24'($urandom);
      step();
      n_tests++;
      if (tick_o !== m_tick || a0_o !== m_a0 || a1_o !== m_a1 || und_o !== m_und) begin
        n_fail++;
        $display("FAIL rand_out i=%0d got tick=%0b a=%h/%h und=%0b exp %0b %h/%h %0b",
                 i, tick_o, a0_o, a1_o, und_o, m_tick, m_a0, m_a1, m_und);
      end
      n_tests++;
      if (play_o !== m_play || level_o !== 5'(m_q.size()) ||
          req_o !== (m_play && m_q.size() <= WM) ||
          ready_o !== ((m_q.size() < DEPTH) && !clr)) begin
        n_fail++;
        $display("FAIL rand_ctl i=%0d got play=%0b lvl=%0d req=%0b rdy=%0b exp play=%0b lvl=%0d",
                 i, play_o, level_o, req_o, ready_o, m_play, m_q.size());
      end
    end
    cfg = 0; clr = 0; wv = 0; play = 0;
    step();
  endtask

  initial begin
    m_reset();
    #3;
    test_reset();
    test_rate();
    test_underrun();
    test_full();
    test_watermark();
    test_cfg_guard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
